// File: rtl/kf8237_transfer_controller.sv
// Four-channel DMA timing and priority controller: arbitrates requests, runs the
// HRQ/HLDA handshake and steps each transfer through SI, S0, S1-S4 and SE.
module kf8237_transfer_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       master_clear,
    input  logic [3:0] dma_request,
    input  logic [3:0] mask,
    input  logic       controller_disable,
    input  logic       rotating_priority,
    input  logic [7:0] transfer_mode,
    input  logic [3:0] autoinitialize,
    input  logic       hold_acknowledge,
    input  logic       underflow,
    input  logic       read_status,
    output logic       hold_request,
    output logic [3:0] dma_acknowledge_internal,
    output logic       address_enable,
    output logic       next_word,
    output logic       initialize_current_register,
    output logic       end_of_process,
    output logic [3:0] terminal_count,
    output logic [3:0] set_mask
);

    localparam logic [2:0] ST_SI = 3'd0;
    localparam logic [2:0] ST_S0 = 3'd1;
    localparam logic [2:0] ST_S1 = 3'd2;
    localparam logic [2:0] ST_S2 = 3'd3;
    localparam logic [2:0] ST_S3 = 3'd4;
    localparam logic [2:0] ST_S4 = 3'd5;
    localparam logic [2:0] ST_SE = 3'd6;

    localparam logic [1:0] MODE_DEMAND = 2'b00;
    localparam logic [1:0] MODE_BLOCK  = 2'b10;

    logic [2:0] state;
    logic [2:0] state_next;
    logic [1:0] channel;
    logic [1:0] priority_base;
    logic [3:0] eligible;
    logic       any_eligible;
    logic [1:0] winner;
    logic       found;
    logic [1:0] scan_base;
    logic [1:0] channel_mode;
    logic [3:0] channel_onehot;
    logic [3:0] tc_set;
    logic       in_transfer;
    logic       terminal;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible[i] = dma_request[i] & ~mask[i] & (transfer_mode[2*i +: 2] != 2'b11)
                          & ~controller_disable;
        end
    end

    assign any_eligible = |eligible;

    // Scan from the highest-priority channel upward; fixed mode always starts at ch0.
    always_comb begin
        winner    = 2'd0;
        found     = 1'b0;
        scan_base = rotating_priority ? priority_base : 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && eligible[scan_base + 2'(i)]) begin
                winner = scan_base + 2'(i);
                found  = 1'b1;
            end
        end
    end

    assign channel_mode   = transfer_mode[{channel, 1'b0} +: 2];
    assign channel_onehot = 4'b0001 << channel;
    assign terminal       = (state == ST_SE) && underflow;
    assign tc_set         = terminal ? channel_onehot : 4'b0000;

    // Handshake: HRQ is raised from S0 and held through SE; the bus is only
    // taken once HLDA is seen in S0, and HLDA loss is honoured only at SE.
    always_comb begin
        state_next = state;
        case (state)
            ST_SI: if (any_eligible) state_next = ST_S0;
            ST_S0: begin
                if (!any_eligible)         state_next = ST_SI;
                else if (hold_acknowledge) state_next = ST_S1;
            end
            ST_S1: state_next = ST_S2;
            ST_S2: state_next = ST_S3;
            ST_S3: state_next = ST_S4;
            ST_S4: state_next = ST_SE;
            ST_SE: begin
                state_next = ST_SI;
                if (!underflow && hold_acknowledge) begin
                    if (channel_mode == MODE_BLOCK)
                        state_next = ST_S1;
                    else if (channel_mode == MODE_DEMAND && dma_request[channel])
                        state_next = ST_S1;
                end
            end
            default: state_next = ST_SI;
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_SI;
            channel        <= 2'd0;
            priority_base  <= 2'd0;
            terminal_count <= 4'b0000;
        end else if (master_clear) begin
            state          <= ST_SI;
            channel        <= 2'd0;
            priority_base  <= 2'd0;
            terminal_count <= 4'b0000;
        end else begin
            state <= state_next;
            if (state == ST_S0 && any_eligible && hold_acknowledge)
                channel <= winner;
            if (state == ST_SE)
                priority_base <= channel + 2'd1;
            // A status read clears old bits but never loses a terminal count set on the same edge.
            terminal_count <= read_status ? tc_set : (terminal_count | tc_set);
        end
    end

    assign in_transfer = (state == ST_S1) || (state == ST_S2) || (state == ST_S3)
                         || (state == ST_S4) || (state == ST_SE);

    // master_clear silences every output in the cycle it is seen.
    always_comb begin
        hold_request                = (state != ST_SI) && !master_clear;
        dma_acknowledge_internal    = (in_transfer && !master_clear) ? channel_onehot : 4'b0000;
        address_enable              = in_transfer && (state != ST_SE) && !master_clear;
        next_word                   = (state == ST_S4) && !master_clear;
        end_of_process              = terminal && !master_clear;
        initialize_current_register = terminal && !master_clear && autoinitialize[channel];
        set_mask                    = (terminal && !master_clear && !autoinitialize[channel])
                                      ? channel_onehot : 4'b0000;
    end

endmodule

// File: tb/tb_kf8237_transfer_controller.sv
// Directed bench for kf8237_transfer_controller: state advances on the falling
// edge; inputs are driven and outputs sampled shortly after it.
module tb_kf8237_transfer_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       master_clear;
    logic [3:0] dma_request;
    logic [3:0] mask;
    logic       controller_disable;
    logic       rotating_priority;
    logic [7:0] transfer_mode;
    logic [3:0] autoinitialize;
    logic       hold_acknowledge;
    logic       underflow;
    logic       read_status;
    logic       hold_request;
    logic [3:0] dma_acknowledge_internal;
    logic       address_enable;
    logic       next_word;
    logic       initialize_current_register;
    logic       end_of_process;
    logic [3:0] terminal_count;
    logic [3:0] set_mask;

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] obs;
    logic [16:0] exp_v;

    kf8237_transfer_controller dut (
        .clock                       (clock),
        .reset                       (reset),
        .master_clear                (master_clear),
        .dma_request                 (dma_request),
        .mask                        (mask),
        .controller_disable          (controller_disable),
        .rotating_priority           (rotating_priority),
        .transfer_mode               (transfer_mode),
        .autoinitialize              (autoinitialize),
        .hold_acknowledge            (hold_acknowledge),
        .underflow                   (underflow),
        .read_status                 (read_status),
        .hold_request                (hold_request),
        .dma_acknowledge_internal    (dma_acknowledge_internal),
        .address_enable              (address_enable),
        .next_word                   (next_word),
        .initialize_current_register (initialize_current_register),
        .end_of_process              (end_of_process),
        .terminal_count              (terminal_count),
        .set_mask                    (set_mask)
    );

    always #5 clock = ~clock;

    assign obs = {hold_request, dma_acknowledge_internal, address_enable, next_word,
                  initialize_current_register, end_of_process, terminal_count, set_mask};

    function automatic logic [16:0] pack(input logic hrq, input logic [3:0] ack,
                                         input logic aen, input logic nw, input logic icr,
                                         input logic eop, input logic [3:0] tc,
                                         input logic [3:0] sm);
        return {hrq, ack, aen, nw, icr, eop, tc, sm};
    endfunction

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1; master_clear = 1'b0; dma_request = 4'b0000; mask = 4'b0000;
        controller_disable = 1'b0; rotating_priority = 1'b0; transfer_mode = 8'h55;
        autoinitialize = 4'b0000; hold_acknowledge = 1'b0; underflow = 1'b0; read_status = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; master_clear = 1'b0; dma_request = 4'b1111; mask = 4'b0000;
        controller_disable = 1'b0; rotating_priority = 1'b0; transfer_mode = 8'h55;
        autoinitialize = 4'b0000; hold_acknowledge = 1'b1; underflow = 1'b0; read_status = 1'b0;
        tick;
        #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs, 17'd0); end
        apply_reset;
        #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, 17'd0); end
    endtask

    task automatic test_eligibility;
        apply_reset;
        hold_acknowledge = 1'b0;
        dma_request = 4'b0001; controller_disable = 1'b1;
        tick; #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL elig_disable: got %h expected %h", obs, 17'd0); end
        controller_disable = 1'b0; mask = 4'b0001;
        tick; #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL elig_mask: got %h expected %h", obs, 17'd0); end
        mask = 4'b0000; transfer_mode = 8'b01_01_01_11;
        tick; #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL elig_mode11: got %h expected %h", obs, 17'd0); end
        transfer_mode = 8'h55;
        tick; #1;
        exp_v = pack(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL elig_s0: got %h expected %h", obs, exp_v); end
        dma_request = 4'b0000;
        tick; #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL elig_s0_drop: got %h expected %h", obs, 17'd0); end
    endtask

    task automatic test_fixed_priority;
        int nw_count;
        apply_reset;
        dma_request = 4'b1010;
        #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL fixed_si: got %h expected %h", obs, 17'd0); end
        exp_v = pack(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        tick; #1;
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL fixed_s0: got %h expected %h", obs, exp_v); end
        tick; #1;
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL fixed_s0_wait: got %h expected %h", obs, exp_v); end
        hold_acknowledge = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_v = pack(1'b1, 4'b0010, 1'b1, (i == 3), 1'b0, 1'b0, 4'b0000, 4'b0000);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL fixed_ch1_s%0d: got %h expected %h", i + 1, obs, exp_v); end
            tick;
        end
        dma_request = 4'b1000;
        #1;
        exp_v = pack(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL fixed_ch1_se: got %h expected %h", obs, exp_v); end
        tick; #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL fixed_back_to_si: got %h expected %h", obs, 17'd0); end
        tick;
        tick;
        nw_count = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            nw_count += int'(next_word);
            n_checks++;
            if (dma_acknowledge_internal !== 4'b1000) begin
                n_fail++; $display("FAIL fixed_ch3_ack_c%0d: got %b expected %b", i, dma_acknowledge_internal, 4'b1000);
            end
            if (i == 4) dma_request = 4'b0000;
            tick;
        end
        n_checks++;
        if (nw_count !== 1) begin n_fail++; $display("FAIL fixed_ch3_next_word_count: got %0d expected 1", nw_count); end
    endtask

    task automatic test_rotating;
        logic [3:0] exp_ack [4];
        exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0100; exp_ack[2] = 4'b0001; exp_ack[3] = 4'b0100;
        apply_reset;
        rotating_priority = 1'b1; hold_acknowledge = 1'b1; dma_request = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            tick;
            tick;
            #1;
            n_checks++;
            if (dma_acknowledge_internal !== exp_ack[t]) begin
                n_fail++; $display("FAIL rot_grant%0d: got %b expected %b", t, dma_acknowledge_internal, exp_ack[t]);
            end
            tick; tick; tick;
            tick;
            if (t == 3) dma_request = 4'b1001;
            tick;
        end
        tick;
        tick;
        #1;
        n_checks++;
        if (dma_acknowledge_internal !== 4'b1000) begin
            n_fail++; $display("FAIL rot_ch3_highest: got %b expected %b", dma_acknowledge_internal, 4'b1000);
        end
        dma_request = 4'b0000;
        repeat (5) tick;
    endtask

    task automatic test_block(input logic ai);
        int nw_count;
        int eop_count;
        apply_reset;
        transfer_mode = 8'b01_01_10_01; autoinitialize = {2'b00, ai, 1'b0};
        hold_acknowledge = 1'b1; dma_request = 4'b0010;
        nw_count = 0; eop_count = 0;
        tick;
        tick;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 4; i++) begin
                #1;
                nw_count += int'(next_word);
                eop_count += int'(end_of_process);
                n_checks++;
                if ({hold_request, dma_acknowledge_internal} !== 5'b1_0010) begin
                    n_fail++; $display("FAIL block_hold_t%0d_s%0d: got %b expected %b", t, i + 1,
                                       {hold_request, dma_acknowledge_internal}, 5'b1_0010);
                end
                tick;
            end
            if (t == 2) begin underflow = 1'b1; dma_request = 4'b0000; end
            #1;
            eop_count += int'(end_of_process);
            if (t < 2) exp_v = pack(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
            else       exp_v = pack(1'b1, 4'b0010, 1'b0, 1'b0, ai, 1'b1, 4'b0000, ai ? 4'b0000 : 4'b0010);
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL block_se%0d_ai%0d: got %h expected %h", t, ai, obs, exp_v); end
            tick;
            underflow = 1'b0;
        end
        #1;
        exp_v = pack(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL block_si_tc_ai%0d: got %h expected %h", ai, obs, exp_v); end
        n_checks++;
        if (nw_count !== 3) begin n_fail++; $display("FAIL block_next_word_count: got %0d expected 3", nw_count); end
        n_checks++;
        if (eop_count !== 1) begin n_fail++; $display("FAIL block_eop_count: got %0d expected 1", eop_count); end
    endtask

    task automatic test_read_status;
        dma_request = 4'b0001;
        tick;
        tick;
        repeat (4) tick;
        underflow = 1'b1; read_status = 1'b1; dma_request = 4'b0000;
        #1;
        exp_v = pack(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0001);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rs_ch0_se: got %h expected %h", obs, exp_v); end
        tick;
        underflow = 1'b0; read_status = 1'b0;
        #1;
        n_checks++;
        if (terminal_count !== 4'b0001) begin n_fail++; $display("FAIL rs_overlap: got %b expected %b", terminal_count, 4'b0001); end
        read_status = 1'b1;
        tick;
        read_status = 1'b0;
        #1;
        n_checks++;
        if (terminal_count !== 4'b0000) begin n_fail++; $display("FAIL rs_clear: got %b expected %b", terminal_count, 4'b0000); end
    endtask

    task automatic test_demand;
        apply_reset;
        transfer_mode = 8'b01_00_01_01; dma_request = 4'b0100; hold_acknowledge = 1'b1;
        tick;
        tick;
        repeat (4) tick;
        #1;
        exp_v = pack(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL demand_se1: got %h expected %h", obs, exp_v); end
        tick; #1;
        exp_v = pack(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL demand_s1_again: got %h expected %h", obs, exp_v); end
        tick;
        dma_request = 4'b0000;
        tick;
        tick; #1;
        exp_v = pack(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL demand_s4: got %h expected %h", obs, exp_v); end
        tick; #1;
        exp_v = pack(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL demand_se2: got %h expected %h", obs, exp_v); end
        tick; #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL demand_si: got %h expected %h", obs, 17'd0); end
    endtask

    task automatic test_master_clear;
        master_clear = 1'b1;
        tick;
        master_clear = 1'b0;
        #1;
        n_checks++;
        if (terminal_count !== 4'b0000) begin n_fail++; $display("FAIL mc_tc_clear: got %b expected %b", terminal_count, 4'b0000); end
        transfer_mode = 8'h55; autoinitialize = 4'b0000; dma_request = 4'b0001; hold_acknowledge = 1'b1;
        tick; tick; tick; tick;
        #1;
        exp_v = pack(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mc_s3: got %h expected %h", obs, exp_v); end
        master_clear = 1'b1; dma_request = 4'b0000;
        #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL mc_same_cycle: got %h expected %h", obs, 17'd0); end
        tick;
        master_clear = 1'b0;
        #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL mc_next: got %h expected %h", obs, 17'd0); end
        tick; #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL mc_no_strobe: got %h expected %h", obs, 17'd0); end
        dma_request = 4'b0001;
        tick; tick; tick;
        #1;
        exp_v = pack(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL rst_s2: got %h expected %h", obs, exp_v); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL rst_async: got %h expected %h", obs, 17'd0); end
        dma_request = 4'b0000;
        tick;
        reset = 1'b0;
        tick; #1;
        n_checks++;
        if (obs !== 17'd0) begin n_fail++; $display("FAIL rst_after: got %h expected %h", obs, 17'd0); end
    endtask

    initial begin
        test_reset;
        test_eligibility;
        test_fixed_priority;
        test_rotating;
        test_block(1'b0);
        test_master_clear;
        test_block(1'b1);
        test_read_status;
        test_demand;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
